ins_assembler: RTL and testbench
================================

INS_ASSEMBLER -- requirements
Module: ins_assembler

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 1024, meaning the number of words emitted before the block stops accepting input.
REQ-002 SHALL have parameter RESET_BASE, default 32'h0000_0000, meaning the p_count value after reset.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  field bundle present.
REQ-006 in_ready  output  1  bundle accepted on a cycle where in_valid && in_ready.
REQ-007 fmt  input  2  format select: 0=R, 1=I, 2=J, 3=reserved.
REQ-008 opcode  input  6  opcode field.
REQ-009 rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-010 funct  input  6  R-type function field.
REQ-011 immediate  input  16  I-type immediate field.
REQ-012 address  input  26  J-type target field.
REQ-013 load_base  input  1  load base_addr into p_count and clear the word count.
REQ-014 base_addr  input  32  new p_count value.
REQ-015 out_valid  output  1  instruction and p_count hold a word.
REQ-016 out_ready  input  1  consumer takes the word on out_valid && out_ready.
REQ-017 instruction  output  32  encoded word.
REQ-018 p_count  output  32  byte address of the presented word.
REQ-019 err  output  1  sticky illegal-bundle flag.
REQ-020 full  output  1  word count equals MAX_WORDS.

Function
REQ-021 R encoding: {6'h0, rs, rt, rd, shamt, funct}; the legal condition is opcode==6'h0.
REQ-022 I encoding: {opcode, rs, rt, immediate}; the legal condition is opcode not in {6'h0, 6'h2, 6'h3}.
REQ-023 J encoding: {opcode, address}; the legal condition is opcode in {6'h2, 6'h3}.
REQ-024 Fields not used by the selected format SHALL be ignored.
REQ-025 in_ready = !load_base && !full && (!out_valid || out_ready).
REQ-026 An accepted legal bundle SHALL appear on instruction/out_valid the next cycle (latency 1), registered.
REQ-027 An accepted illegal bundle (fmt==3 or opcode mismatch) SHALL be dropped, SHALL set err, and SHALL NOT change p_count or the count.
REQ-028 Output states:
- EMPTY (out_valid=0) -> HOLD on a legal accept.
- HOLD -> EMPTY on a take with no new legal accept.
- HOLD -> HOLD on a take with a simultaneous legal accept (back-to-back).
REQ-029 In HOLD with out_ready=0, instruction and p_count SHALL stay stable.
REQ-030 Presented p_count SHALL equal the base for the first word after load/reset, then increase by 4 per emitted word.
REQ-031 p_count SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-032 The word count SHALL increment on each legal accept; full SHALL assert when count==MAX_WORDS.
REQ-033 full SHALL clear only on load_base or reset.
REQ-034 load_base SHALL take priority over input: no accept that cycle.
REQ-035 load_base SHALL load p_count, clear the count and err, and leave a word already in HOLD presented with its original p_count.
REQ-036 err SHALL clear only on load_base or reset.

Reset
REQ-037 On rst_n low, immediately and asynchronously: out_valid=0, instruction=0, p_count=RESET_BASE, err=0, full=0, count=0, EMPTY state.
REQ-038 in_ready SHALL be 0 while rst_n is low, and SHALL be 1 from the first clock edge after release.
REQ-039 Reset asserted mid-transfer SHALL discard the held word.

Verification
REQ-040 Encode cases, each presented at p_count 0 then 4 then 8:
- fmt=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20 -> 32'h012A4020.
- fmt=1, opcode=8, rs=9, rt=8, imm=5 -> 32'h21280005.
- fmt=2, opcode=2, address=26'h0100000 -> 32'h08100000.
REQ-041 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, word and p_count stable; then out_ready=1 -> back-to-back delivery, one word per cycle.
REQ-042 Illegal: fmt=0 with opcode=8, then fmt=3 -> both dropped, err=1, next legal word still at p_count 0.
REQ-043 Full/load: MAX_WORDS=2, three legal bundles -> two emitted, full=1, in_ready=0; then load_base with base_addr=32'h0040_0000 -> full=0, next word at p_count 32'h0040_0000.
REQ-044 Wrap and reset: base_addr=32'hFFFF_FFFC, two words -> p_count FFFF_FFFC then 0000_0000; rst_n low mid-HOLD -> out_valid=0 immediately, before any clock edge.

Source files
------------

// File: rtl/ins_assembler_if.sv
// Bus between a field-bundle producer, ins_assembler and the word consumer.
// Handshake: a transfer occurs on a rising edge where valid && ready. A source
// keeps valid and its payload steady until it transfers. Ready never looks at valid.
interface ins_assembler_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] address;
    logic        load_base;
    logic [31:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] p_count;
    logic        err;
    logic        full;

    modport master (
        output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, immediate,
               address, load_base, base_addr, out_ready,
        input  in_ready, out_valid, instruction, p_count, err, full
    );

    modport slave (
        input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, immediate,
               address, load_base, base_addr, out_ready,
        output in_ready, out_valid, instruction, p_count, err, full
    );
endinterface

// File: rtl/ins_assembler.sv
// Encodes R/I/J field bundles into 32-bit words. Each word is tagged with its
// byte address. A one-entry output register holds the word until it is taken.
module ins_assembler #(
    parameter int          MAX_WORDS  = 1024,
    parameter logic [31:0] RESET_BASE = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    ins_assembler_if.slave bus,
    output logic           dbg_hold
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ready_en;
    logic [31:0]   word_q;
    logic [31:0]   pc_q;
    logic [31:0]   pc_next;
    logic [CW-1:0] count;
    logic          err_q;
    logic          legal;
    logic [31:0]   word;
    logic          full_w;
    logic          take;
    logic          accept;
    logic          emit;

    assign full_w   = (count == CW'(MAX_WORDS));
    assign take     = (state == HOLD) && bus.out_ready;
    assign bus.in_ready = ready_en && !bus.load_base && !full_w &&
                          ((state == EMPTY) || bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready;
    assign emit     = accept && legal;

    assign bus.out_valid   = (state == HOLD);
    assign bus.instruction = word_q;
    assign bus.p_count     = pc_q;
    assign bus.err         = err_q;
    assign bus.full        = full_w;
    assign dbg_hold        = (state == HOLD);

    // Opcodes 2 and 3 (6'b00001x) belong to J; I takes every other non-zero opcode.
    always_comb begin
        legal = 1'b0;
        word  = 32'h0000_0000;
        case (bus.fmt)
            2'd0: begin
                legal = (bus.opcode == 6'h00);
                word  = {6'h00, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            end
            2'd1: begin
                legal = (bus.opcode != 6'h00) && (bus.opcode[5:1] != 5'b00001);
                word  = {bus.opcode, bus.rs, bus.rt, bus.immediate};
            end
            2'd2: begin
                legal = (bus.opcode[5:1] == 5'b00001);
                word  = {bus.opcode, bus.address};
            end
            default: begin
                legal = 1'b0;
                word  = 32'h0000_0000;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (emit) state_nxt = HOLD;
            HOLD:    if (take && !emit) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // pc_next is the address the next accepted word gets; pc_q is the presented one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            word_q   <= 32'h0000_0000;
            pc_q     <= RESET_BASE;
            pc_next  <= RESET_BASE;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (bus.load_base) begin
                pc_next <= bus.base_addr;
                count   <= '0;
                err_q   <= 1'b0;
                if (state == EMPTY) pc_q <= bus.base_addr;
            end else if (accept) begin
                if (legal) begin
                    word_q  <= word;
                    pc_q    <= pc_next;
                    pc_next <= pc_next + 32'd4;
                    count   <= count + CW'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ins_assembler.sv
// Directed and randomized bench for ins_assembler, with a queue-based reference model.
module tb_ins_assembler;
    localparam int          MAXW = 1024;
    localparam logic [31:0] RB   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic hold_main;
    logic hold_small;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ins_assembler_if d();
    ins_assembler_if s();

    ins_assembler #(.MAX_WORDS(MAXW), .RESET_BASE(RB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(d), .dbg_hold(hold_main)
    );

    ins_assembler #(.MAX_WORDS(2), .RESET_BASE(RB)) dut_small (
        .clk(clk), .rst_n(rst_n), .bus(s), .dbg_hold(hold_small)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Returns {legal, word} computed from the format rules.
    function automatic logic [32:0] ref_encode(input logic [1:0] f, input logic [5:0] op,
                                               input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] sh,
                                               input logic [5:0] fn, input logic [15:0] imm,
                                               input logic [25:0] addr);
        logic [31:0] w;
        logic        ok;
        ok = 1'b0;
        w  = 32'h0;
        if (f == 2'd0) begin
            ok = (op == 6'h00);
            w  = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
        end else if (f == 2'd1) begin
            ok = !(op inside {6'h00, 6'h02, 6'h03});
            w  = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        end else if (f == 2'd2) begin
            ok = (op inside {6'h02, 6'h03});
            w  = (32'(op) << 26) | 32'(addr);
        end
        return {ok, w};
    endfunction

    // Scoreboard: each entry is {p_count, instruction}.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc  = RB;
    int          m_cnt = 0;
    logic        m_err = 1'b0;

    always @(negedge clk) begin
        logic [63:0] e;
        logic [32:0] r;
        if (!rst_n) begin
            exp_q.delete();
            m_pc  = RB;
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            chk1("mon_out_valid", d.out_valid, exp_q.size() != 0);
            chk1("mon_err", d.err, m_err);
            chk1("mon_full", d.full, m_cnt == MAXW);
            if (d.out_valid && d.out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk32("mon_instruction", d.instruction, e[31:0]);
                chk32("mon_p_count", d.p_count, e[63:32]);
            end
            if (d.load_base) begin
                m_pc  = d.base_addr;
                m_cnt = 0;
                m_err = 1'b0;
            end else if (d.in_valid && d.in_ready) begin
                r = ref_encode(d.fmt, d.opcode, d.rs, d.rt, d.rd, d.shamt, d.funct,
                               d.immediate, d.address);
                if (r[32]) begin
                    exp_q.push_back({m_pc, r[31:0]});
                    m_pc  = m_pc + 32'd4;
                    m_cnt = m_cnt + 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] addr);
        d.fmt = f; d.opcode = op; d.rs = rs; d.rt = rt; d.rd = rd;
        d.shamt = sh; d.funct = fn; d.immediate = imm; d.address = addr;
    endtask

    // Presents the current fields and waits (bounded) for the accepting edge.
    task automatic push();
        logic ok;
        ok = 1'b0;
        d.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (d.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        d.in_valid = 1'b0;
        chk1("push_accept", ok, 1'b1);
    endtask

    task automatic do_load(input logic [31:0] b);
        d.load_base = 1'b1;
        d.base_addr = b;
        #1;
        chk1("load_blocks_ready", d.in_ready, 1'b0);
        @(posedge clk); #1;
        d.load_base = 1'b0;
    endtask

    initial begin
        logic [31:0] enc_exp[3];
        logic [31:0] wa, wb, wc;
        logic [32:0] r;
        logic [1:0]  f;
        logic [5:0]  op;
        logic        acc;
        logic        got;
        int          takes;

        enc_exp = '{32'h012A4020, 32'h21280005, 32'h08100000};
        rst_n = 1'b0;
        d.in_valid = 1'b0; d.load_base = 1'b0; d.base_addr = 32'h0; d.out_ready = 1'b1;
        s.in_valid = 1'b0; s.load_base = 1'b0; s.base_addr = 32'h0; s.out_ready = 1'b1;
        s.fmt = 2'd1; s.opcode = 6'h08; s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd0;
        s.shamt = 5'd0; s.funct = 6'd0; s.immediate = 16'h1234; s.address = 26'h0;
        set_fields(2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_out_valid", d.out_valid, 1'b0);
        chk32("rst_instruction", d.instruction, 32'h0);
        chk32("rst_p_count", d.p_count, RB);
        chk1("rst_err", d.err, 1'b0);
        chk1("rst_full", d.full, 1'b0);
        chk1("rst_in_ready", d.in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("release_in_ready_low", d.in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("first_edge_in_ready", d.in_ready, 1'b1);

        // Encode cases, each at p_count 0, 4, 8
        for (int c = 0; c < 3; c++) begin
            do_load(32'h0);
            for (int k = 0; k < 3; k++) begin
                if (c == 0) set_fields(2'd0, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'hBEEF, 26'h3FFFFFF);
                else if (c == 1) set_fields(2'd1, 6'h08, 5'd9, 5'd8, 5'd31, 5'd31, 6'h3F, 16'd5, 26'h155);
                else set_fields(2'd2, 6'h02, 5'd7, 5'd7, 5'd7, 5'd7, 6'h11, 16'hFFFF, 26'h0100000);
                push();
                chk1("enc_out_valid", d.out_valid, 1'b1);
                chk32("enc_word", d.instruction, enc_exp[c]);
                chk32("enc_p_count", d.p_count, 32'(k * 4));
            end
        end

        // Backpressure then back-to-back delivery
        @(posedge clk); #1;
        do_load(32'h0);
        d.out_ready = 1'b0;
        set_fields(2'd1, 6'h23, 5'($urandom), 5'($urandom), 5'd0, 5'd0, 6'd0, 16'($urandom), 26'd0);
        r = ref_encode(d.fmt, d.opcode, d.rs, d.rt, d.rd, d.shamt, d.funct, d.immediate, d.address);
        wa = r[31:0];
        push();
        set_fields(2'd0, 6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'd0, 26'd0);
        r = ref_encode(d.fmt, d.opcode, d.rs, d.rt, d.rd, d.shamt, d.funct, d.immediate, d.address);
        wb = r[31:0];
        d.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("bp_in_ready", d.in_ready, 1'b0);
            chk32("bp_word_stable", d.instruction, wa);
            chk32("bp_pc_stable", d.p_count, 32'h0);
            @(posedge clk); #1;
        end
        d.out_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_ready", d.in_ready, 1'b1);
        @(posedge clk); #1;
        set_fields(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'($urandom));
        r = ref_encode(d.fmt, d.opcode, d.rs, d.rt, d.rd, d.shamt, d.funct, d.immediate, d.address);
        wc = r[31:0];
        chk1("b2b_valid_1", d.out_valid, 1'b1);
        chk32("b2b_word_1", d.instruction, wb);
        chk32("b2b_pc_1", d.p_count, 32'h4);
        @(negedge clk);
        chk1("b2b_ready", d.in_ready, 1'b1);
        @(posedge clk); #1;
        d.in_valid = 1'b0;
        chk1("b2b_valid_2", d.out_valid, 1'b1);
        chk32("b2b_word_2", d.instruction, wc);
        chk32("b2b_pc_2", d.p_count, 32'h8);
        @(posedge clk); #1;

        // Illegal bundles are dropped and set err
        do_load(32'h0);
        set_fields(2'd0, 6'h08, 5'd1, 5'd2, 5'd3, 5'd4, 6'h20, 16'd0, 26'd0);
        push();
        chk1("illegal_r_dropped", d.out_valid, 1'b0);
        chk1("illegal_r_err", d.err, 1'b1);
        set_fields(2'd3, 6'h02, 5'd1, 5'd2, 5'd3, 5'd4, 6'h20, 16'd0, 26'd0);
        push();
        chk1("illegal_fmt3_dropped", d.out_valid, 1'b0);
        set_fields(2'd0, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'd0, 26'd0);
        push();
        chk32("after_illegal_word", d.instruction, 32'h012A4020);
        chk32("after_illegal_pc", d.p_count, 32'h0);
        chk1("err_sticky", d.err, 1'b1);
        do_load(32'h0);
        chk1("load_clears_err", d.err, 1'b0);

        // p_count wrap
        do_load(32'hFFFF_FFFC);
        set_fields(2'd1, 6'h0D, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0);
        push();
        chk32("wrap_pc_0", d.p_count, 32'hFFFF_FFFC);
        push();
        chk32("wrap_pc_1", d.p_count, 32'h0000_0000);

        // Asynchronous reset while a word is held
        @(posedge clk); #1;
        do_load(32'h0000_1000);
        d.out_ready = 1'b0;
        push();
        chk1("pre_rst_hold", d.out_valid, 1'b1);
        chk1("pre_rst_dbg", hold_main, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_out_valid", d.out_valid, 1'b0);
        chk32("async_rst_instruction", d.instruction, 32'h0);
        chk32("async_rst_p_count", d.p_count, RB);
        @(posedge clk); #1;
        rst_n = 1'b1;
        d.out_ready = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the scoreboard
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!d.in_valid || acc) begin
                f  = 2'($urandom_range(0, 3));
                op = 6'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    if (f == 2'd0) op = 6'h00;
                    else if (f == 2'd1 && op inside {6'h00, 6'h02, 6'h03}) op = 6'h23;
                    else if (f == 2'd2) op = 6'($urandom_range(2, 3));
                end
                set_fields(f, op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                           6'($urandom), 16'($urandom), 26'($urandom));
                d.in_valid = ($urandom_range(0, 3) != 0);
            end
            d.out_ready = ($urandom_range(0, 2) != 0);
            d.load_base = ($urandom_range(0, 39) == 0);
            d.base_addr = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            @(negedge clk);
            acc = d.in_valid && d.in_ready;
            @(posedge clk); #1;
        end
        d.in_valid = 1'b0;
        d.load_base = 1'b0;
        d.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk32("drain_empty", 32'(exp_q.size()), 32'h0);

        // Full and reload on the MAX_WORDS=2 instance
        s.in_valid = 1'b1;
        takes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s.out_valid && s.out_ready) takes++;
            @(posedge clk); #1;
        end
        chk32("full_takes", 32'(takes), 32'd2);
        chk1("full_set", s.full, 1'b1);
        chk1("full_in_ready", s.in_ready, 1'b0);
        s.load_base = 1'b1;
        s.base_addr = 32'h0040_0000;
        @(posedge clk); #1;
        s.load_base = 1'b0;
        chk1("full_cleared", s.full, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (s.out_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        s.in_valid = 1'b0;
        chk1("reload_word_seen", got, 1'b1);
        chk32("reload_p_count", s.p_count, 32'h0040_0000);
        chk32("reload_word", s.instruction, 32'h20221234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
